// File: rtl/mux151_pkg.sv
// Shared types and sizing for the 74HC151 scan sequencer.
// Holds the state encoding, default channel geometry and the settle counter width.
package mux151_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int SEL_W        = 3;
  localparam int CH_N         = 1 << SEL_W;
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/mux151_settle_timer.sv
// Per-channel settle timer for the scan sequencer.
// It is cleared by load and counts while en is high; expired flags the last settle clock.
module mux151_settle_timer
  import mux151_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [SETTLE_CNT_W-1:0] LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mux151_scan_sequencer.sv
// Walks the 74HC151 through every channel, samples Y after a settle time and checks it
// against YF. The assembled word and the per-channel fault mask are published once per scan.
module mux151_scan_sequencer
  import mux151_pkg::*;
#(
  parameter int DATA_SelectPart  = SEL_W,
  parameter int DATA_Single_Part = CH_N,
  parameter int SETTLE_CYCLES    = 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  input  logic                        continuous,
  output logic                        EN_Part,
  output logic [DATA_SelectPart-1:0]  SelectPart,
  input  logic                        Y,
  input  logic                        YF,
  output logic                        busy,
  output logic                        data_valid,
  output logic [DATA_Single_Part-1:0] data_out,
  output logic [DATA_Single_Part-1:0] fault_mask,
  output logic                        fault
);

  localparam logic [DATA_SelectPart-1:0] LAST_CH = DATA_SelectPart'(DATA_Single_Part - 1);

  state_t                      state, next_state;
  logic [DATA_Single_Part-1:0] cap, fm;
  logic                        expired, timer_load, timer_en;

  mux151_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .load   (timer_load),
    .en     (timer_en),
    .expired(expired)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE:  if (expired) next_state = SAMPLE;
      SAMPLE:  next_state = (SelectPart == LAST_CH) ? DONE : SETTLE;
      DONE:    next_state = (continuous | start) ? SETTLE : IDLE;
      default: next_state = IDLE;
    endcase
    timer_load = (next_state == SETTLE) && (state != SETTLE);
    timer_en   = (state == SETTLE);
  end

  // Register actions belong to the state being left; DONE already points EN_Part at the next scan.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      EN_Part    <= 1'b1;
      SelectPart <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      fault_mask <= '0;
      fault      <= 1'b0;
      cap        <= '0;
      fm         <= '0;
    end else begin
      data_valid <= 1'b0;
      busy       <= (next_state == SETTLE) || (next_state == SAMPLE);
      case (state)
        IDLE: begin
          if (start) begin
            SelectPart <= '0;
            EN_Part    <= 1'b0;
            cap        <= '0;
            fm         <= '0;
          end
        end
        SAMPLE: begin
          cap[SelectPart] <= Y;
          fm[SelectPart]  <= (Y == YF);
          if (SelectPart != LAST_CH) SelectPart <= SelectPart + 1'b1;
        end
        DONE: begin
          data_out   <= cap;
          fault_mask <= fm;
          fault      <= |fm;
          data_valid <= 1'b1;
          SelectPart <= '0;
          EN_Part    <= ~(continuous | start);
          if (continuous | start) begin
            cap <= '0;
            fm  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux151_scan_sequencer.sv
// Bench for the 74HC151 scan sequencer: one instance with default settle, one with settle 1.
// The selector is modelled from a per-scan pattern and forced-fault mask.
module tb_mux151_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, cont_a, start_b, cont_b;
  logic       en_a, en_b, y_a, yf_a, y_b, yf_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b, dv_a, dv_b, fault_a, fault_b;
  logic [7:0] dout_a, dout_b, fm_a, fm_b;
  logic [7:0] pat_a, frc_a, pat_b, frc_b;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always @(posedge clk) cyc++;

  assign y_a  = pat_a[sel_a];
  assign yf_a = frc_a[sel_a] ? y_a : ~y_a;
  assign y_b  = pat_b[sel_b];
  assign yf_b = frc_b[sel_b] ? y_b : ~y_b;

  mux151_scan_sequencer dut_a (
    .CLK(clk), .RST_N(rst_n), .start(start_a), .continuous(cont_a),
    .EN_Part(en_a), .SelectPart(sel_a), .Y(y_a), .YF(yf_a),
    .busy(busy_a), .data_valid(dv_a), .data_out(dout_a),
    .fault_mask(fm_a), .fault(fault_a)
  );

  mux151_scan_sequencer #(.SETTLE_CYCLES(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .start(start_b), .continuous(cont_b),
    .EN_Part(en_b), .SelectPart(sel_b), .Y(y_b), .YF(yf_b),
    .busy(busy_b), .data_valid(dv_b), .data_out(dout_b),
    .fault_mask(fm_b), .fault(fault_b)
  );

  function automatic int scan_lat(input int settle);
    return 1 + 8 * (settle + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit b, output int t0);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    t0 = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_valid(input bit b, input int limit, output bit seen, output int t);
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (b ? dv_b : dv_a) begin
        seen = 1'b1;
        t    = cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_en"},    32'(en_a),    32'd1);
    check({tag, "_sel"},   32'(sel_a),   32'd0);
    check({tag, "_busy"},  32'(busy_a),  32'd0);
    check({tag, "_dv"},    32'(dv_a),    32'd0);
    check({tag, "_dout"},  32'(dout_a),  32'd0);
    check({tag, "_mask"},  32'(fm_a),    32'd0);
    check({tag, "_fault"}, 32'(fault_a), 32'd0);
  endtask

  task automatic do_scan(input bit b, input logic [7:0] pat, input logic [7:0] frc,
                         input int settle, input string tag);
    int t0, t;
    bit seen;
    if (b) begin pat_b = pat; frc_b = frc; end
    else   begin pat_a = pat; frc_a = frc; end
    pulse_start(b, t0);
    wait_valid(b, 80, seen, t);
    check({tag, "_seen"},  32'(seen), 32'd1);
    check({tag, "_lat"},   t - t0, scan_lat(settle));
    check({tag, "_data"},  32'(b ? dout_b : dout_a), 32'(pat));
    check({tag, "_mask"},  32'(b ? fm_b : fm_a), 32'(frc));
    check({tag, "_fault"}, 32'(b ? fault_b : fault_a), 32'(frc != 8'h00));
    @(negedge clk);
    check({tag, "_dv_pulse"}, 32'(b ? dv_b : dv_a), 32'd0);
    check({tag, "_idle"},     32'(b ? busy_b : busy_a), 32'd0);
    check({tag, "_en_off"},   32'(b ? en_b : en_a), 32'd1);
  endtask

  // Channel dwell: every channel after the first lasts settle+1 clocks before the next one.
  logic [2:0] prev_a = '0, prev_b = '0;
  int dwell_a = 0, dwell_b = 0;
  always @(negedge clk) begin
    if (sel_a !== prev_a) begin
      if (prev_a >= 3'd1 && sel_a == prev_a + 1) check("dwell_a", dwell_a, 32'd3);
      dwell_a = 1;
      prev_a  = sel_a;
    end else dwell_a++;
    if (sel_b !== prev_b) begin
      if (prev_b >= 3'd1 && sel_b == prev_b + 1) check("dwell_b", dwell_b, 32'd2);
      dwell_b = 1;
      prev_b  = sel_b;
    end else dwell_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0, t, tp;
    bit  seen;
    logic [7:0] rp, rf;

    rst_n = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
    pat_a = '0; frc_a = '0; pat_b = '0; frc_b = '0;

    // T1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a("t1");
    check("t1_b_en",   32'(en_b),   32'd1);
    check("t1_b_dout", 32'(dout_b), 32'd0);
    rst_n = 1'b1;

    // T2 single scan, T3 forced faults on channels 3 and 6
    do_scan(1'b0, 8'hA5, 8'h00, 2, "t2");
    repeat (4) @(negedge clk);
    check("t2_hold", 32'(dout_a), 32'hA5);
    do_scan(1'b0, 8'hA5, 8'((1 << 3) | (1 << 6)), 2, "t3");

    // random patterns and fault masks
    for (int i = 0; i < 3; i++) begin
      rp = 8'($urandom);
      rf = (i == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
      do_scan(1'b0, rp, rf, 2, $sformatf("rnd%0d", i));
    end

    // T4 continuous: alternating words, no gap, then drop continuous mid-scan
    cont_a = 1'b1;
    pat_a = 8'h3C; frc_a = 8'h00;
    pulse_start(1'b0, t0);
    wait_valid(1'b0, 80, seen, t);
    check("t4_s1_seen", 32'(seen), 32'd1);
    check("t4_s1_lat",  t - t0, scan_lat(2));
    check("t4_s1_data", 32'(dout_a), 32'h3C);
    check("t4_nogap_sel",  32'(sel_a),  32'd0);
    check("t4_nogap_busy", 32'(busy_a), 32'd1);
    check("t4_nogap_en",   32'(en_a),   32'd0);
    pat_a = 8'hC3;
    tp = t;
    wait_valid(1'b0, 80, seen, t);
    check("t4_s2_seen", 32'(seen), 32'd1);
    check("t4_s2_lat",  t - tp, scan_lat(2));
    check("t4_s2_data", 32'(dout_a), 32'hC3);
    pat_a = 8'h3C;
    tp = t;
    repeat (5) @(negedge clk);
    cont_a = 1'b0;
    wait_valid(1'b0, 80, seen, t);
    check("t4_s3_seen", 32'(seen), 32'd1);
    check("t4_s3_lat",  t - tp, scan_lat(2));
    check("t4_s3_data", 32'(dout_a), 32'h3C);
    @(negedge clk);
    check("t4_stop_busy", 32'(busy_a), 32'd0);
    wait_valid(1'b0, 40, seen, t);
    check("t4_stop_novalid", 32'(seen), 32'd0);

    // T5 start re-pulsed while busy is ignored
    pat_a = 8'h5A; frc_a = 8'h00;
    pulse_start(1'b0, t0);
    repeat (9) @(negedge clk);
    check("t5_busy_at10", 32'(busy_a), 32'd1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_valid(1'b0, 80, seen, t);
    check("t5_seen", 32'(seen), 32'd1);
    check("t5_lat",  t - t0, scan_lat(2));
    check("t5_data", 32'(dout_a), 32'h5A);
    wait_valid(1'b0, 40, seen, t);
    check("t5_single", 32'(seen), 32'd0);

    // T5 reset at channel 4 aborts the scan
    pat_a = 8'hFF;
    pulse_start(1'b0, t0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel_a == 3'd4) begin seen = 1'b1; break; end
    end
    check("t5_reach_ch4", 32'(seen), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_a("t5_rst");
    rst_n = 1'b1;
    wait_valid(1'b0, 40, seen, t);
    check("t5_rst_novalid", 32'(seen), 32'd0);

    // T6 settle of one clock
    do_scan(1'b1, 8'h96, 8'h21, 1, "t6");
    do_scan(1'b1, 8'($urandom), 8'h00, 1, "t6r");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
